gp9001_host_if: RTL and testbench

- GP9001 side of the 68k→GCU operation handshake: accepts the six level-held op strobes (select reg, write reg, set RAM pointer, write RAM, read RAM H/L) and executes each one.
- Owns the register-select latch, the scroll/control register file and the auto-incrementing VRAM pointer.
- Drives the VRAM host port (arbitrated externally against the renderer via VRAM_OK).
- Returns read data on DOUT and completes each operation with a four-phase ACK.

---
 rtl/gp9001_pkg.sv | 39 +++
 rtl/gp9001_op_prio.sv | 44 ++++
 rtl/gp9001_host_if.sv | 232 +++++++++++++++++++++++
 tb/tb_gp9001_host_if.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gp9001_pkg.sv
// gp9001_pkg: shared types and constants for the GP9001 host-side block.
//   op_e     : decoded host operation (output of the strobe priority encoder)
//   state_e  : host-handshake FSM states
//   REG_*    : register-file indices used by the renderer
//   is_read_op() : true for the two VRAM read operations
package gp9001_pkg;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_SEL  = 3'd1,
    OP_WREG = 3'd2,
    OP_PTR  = 3'd3,
    OP_WRAM = 3'd4,
    OP_RDH  = 3'd5,
    OP_RDL  = 3'd6
  } op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAMWAIT = 2'd1,
    ACKED   = 2'd2
  } state_e;

  // Register-file map (scroll registers per layer, sprite scroll, control)
  localparam int REG_L0_SCROLL_X  = 0;
  localparam int REG_L0_SCROLL_Y  = 1;
  localparam int REG_L1_SCROLL_X  = 2;
  localparam int REG_L1_SCROLL_Y  = 3;
  localparam int REG_L2_SCROLL_X  = 4;
  localparam int REG_L2_SCROLL_Y  = 5;
  localparam int REG_SPR_SCROLL_X = 6;
  localparam int REG_SPR_SCROLL_Y = 7;
  localparam int REG_CTRL         = 8;

  function automatic logic is_read_op(input op_e op);
    return (op == OP_RDH) || (op == OP_RDL);
  endfunction

endpackage

// File: rtl/gp9001_op_prio.sv
// gp9001_op_prio: combinational priority encoder from the six level-held
// host strobes to a single operation.
//   i_sel/i_wreg/i_ptr/i_wram/i_rdh/i_rdl : op strobes (highest priority first)
//   o_op  : winning operation, OP_NONE when no strobe is high
//   o_any : OR of all six strobes
import gp9001_pkg::*;

module gp9001_op_prio (
  input  logic i_sel,
  input  logic i_wreg,
  input  logic i_ptr,
  input  logic i_wram,
  input  logic i_rdh,
  input  logic i_rdl,
  output op_e  o_op,
  output logic o_any
);

  // any-op indicator used for the four-phase handshake
  always_comb begin
    o_any = i_sel | i_wreg | i_ptr | i_wram | i_rdh | i_rdl;
  end

  // fixed-priority select: SELECT_REG wins over everything else
  always_comb begin
    o_op = OP_NONE;
    if (i_sel) begin
      o_op = OP_SEL;
    end else if (i_wreg) begin
      o_op = OP_WREG;
    end else if (i_ptr) begin
      o_op = OP_PTR;
    end else if (i_wram) begin
      o_op = OP_WRAM;
    end else if (i_rdh) begin
      o_op = OP_RDH;
    end else if (i_rdl) begin
      o_op = OP_RDL;
    end else begin
      o_op = OP_NONE;
    end
  end

endmodule

// File: rtl/gp9001_host_if.sv
// gp9001_host_if: GP9001 side of the 68k->GCU operation handshake.
// Executes one host op per four-phase handshake, owns the register-select
// latch, the 2^RW x 16 register file and the auto-incrementing VRAM pointer.
// Ports:
//   CLK96, RESET96 (async, active-high)
//   OP_* strobes, DIN, BE_N        : host operation request
//   ACK, DOUT                       : completion / read data
//   VRAM_ADDR/WDATA/WE/REQ, VRAM_OK/RDATA : VRAM host port
//   REG_RADDR -> REG_RDATA          : renderer register read (combinational)
//   RAM_PTR                         : current VRAM pointer
import gp9001_pkg::*;

module gp9001_host_if #(
  parameter int AW = 14,
  parameter int RW = 4
) (
  input  logic          CLK96,
  input  logic          RESET96,
  input  logic          OP_SELECT_REG,
  input  logic          OP_WRITE_REG,
  input  logic          OP_SET_RAM_PTR,
  input  logic          OP_WRITE_RAM,
  input  logic          OP_READ_RAM_H,
  input  logic          OP_READ_RAM_L,
  input  logic [15:0]   DIN,
  input  logic [1:0]    BE_N,
  output logic          ACK,
  output logic [15:0]   DOUT,
  output logic [AW-1:0] VRAM_ADDR,
  output logic [15:0]   VRAM_WDATA,
  output logic [1:0]    VRAM_WE,
  output logic          VRAM_REQ,
  input  logic          VRAM_OK,
  input  logic [15:0]   VRAM_RDATA,
  input  logic [RW-1:0] REG_RADDR,
  output logic [15:0]   REG_RDATA,
  output logic [AW-1:0] RAM_PTR
);

  localparam int NREG = 2 ** RW;

  op_e           w_op;
  logic          w_any_op;

  state_e        r_state;
  state_e        w_state_nxt;
  logic [RW-1:0] r_sel;
  logic [RW-1:0] w_sel_nxt;
  logic [15:0]   r_regs [NREG];
  logic          w_reg_we;
  logic [AW-1:0] r_ptr;
  logic [AW-1:0] w_ptr_nxt;
  logic          r_rd;
  logic          w_rd_nxt;
  logic          r_ack;
  logic          w_ack_nxt;
  logic [15:0]   r_dout;
  logic [15:0]   w_dout_nxt;
  logic [AW-1:0] r_vaddr;
  logic [AW-1:0] w_vaddr_nxt;
  logic [15:0]   r_vwdata;
  logic [15:0]   w_vwdata_nxt;
  logic [1:0]    r_vwe;
  logic [1:0]    w_vwe_nxt;
  logic          r_vreq;
  logic          w_vreq_nxt;

  gp9001_op_prio u_prio (
    .i_sel  (OP_SELECT_REG),
    .i_wreg (OP_WRITE_REG),
    .i_ptr  (OP_SET_RAM_PTR),
    .i_wram (OP_WRITE_RAM),
    .i_rdh  (OP_READ_RAM_H),
    .i_rdl  (OP_READ_RAM_L),
    .o_op   (w_op),
    .o_any  (w_any_op)
  );

  // FSM state register
  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state and next-value logic for every registered output
  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_sel;
    w_reg_we     = 1'b0;
    w_ptr_nxt    = r_ptr;
    w_rd_nxt     = r_rd;
    w_ack_nxt    = r_ack;
    w_dout_nxt   = r_dout;
    w_vaddr_nxt  = r_vaddr;
    w_vwdata_nxt = r_vwdata;
    w_vwe_nxt    = r_vwe;
    w_vreq_nxt   = r_vreq;

    case (r_state)
      IDLE: begin
        w_ack_nxt = 1'b0;
        // lower-priority strobes raised alongside are simply ignored
        case (w_op)
          OP_SEL: begin
            w_sel_nxt   = DIN[RW-1:0];
            w_ack_nxt   = 1'b1;
            w_state_nxt = ACKED;
          end
          OP_WREG: begin
            w_reg_we    = 1'b1;
            w_ack_nxt   = 1'b1;
            w_state_nxt = ACKED;
          end
          OP_PTR: begin
            w_ptr_nxt   = DIN[AW-1:0];
            w_ack_nxt   = 1'b1;
            w_state_nxt = ACKED;
          end
          OP_WRAM: begin
            w_vaddr_nxt  = r_ptr;
            w_vwdata_nxt = DIN;
            w_vwe_nxt    = ~BE_N;
            w_vreq_nxt   = 1'b1;
            w_rd_nxt     = 1'b0;
            w_state_nxt  = RAMWAIT;
          end
          OP_RDH, OP_RDL: begin
            w_vaddr_nxt = r_ptr;
            w_vwe_nxt   = 2'b00;
            w_vreq_nxt  = 1'b1;
            w_rd_nxt    = is_read_op(w_op);
            w_state_nxt = RAMWAIT;
          end
          default: begin
            w_state_nxt = IDLE;
          end
        endcase
      end

      RAMWAIT: begin
        if (VRAM_OK) begin
          w_vreq_nxt = 1'b0;
          w_vwe_nxt  = 2'b00;
          w_ptr_nxt  = r_ptr + {{(AW-1){1'b0}}, 1'b1};
          if (r_rd) begin
            w_dout_nxt = VRAM_RDATA;
          end else begin
            w_dout_nxt = r_dout;
          end
          // strobe already dropped: access finishes silently, no ACK
          if (w_any_op) begin
            w_ack_nxt   = 1'b1;
            w_state_nxt = ACKED;
          end else begin
            w_ack_nxt   = 1'b0;
            w_state_nxt = IDLE;
          end
        end else begin
          w_state_nxt = RAMWAIT;
        end
      end

      ACKED: begin
        if (!w_any_op) begin
          w_ack_nxt   = 1'b0;
          w_state_nxt = IDLE;
        end else begin
          w_ack_nxt   = 1'b1;
          w_state_nxt = ACKED;
        end
      end

      default: begin
        w_ack_nxt   = 1'b0;
        w_vreq_nxt  = 1'b0;
        w_vwe_nxt   = 2'b00;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // datapath and handshake output registers
  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      r_sel    <= {RW{1'b0}};
      r_ptr    <= {AW{1'b0}};
      r_rd     <= 1'b0;
      r_ack    <= 1'b0;
      r_dout   <= 16'h0000;
      r_vaddr  <= {AW{1'b0}};
      r_vwdata <= 16'h0000;
      r_vwe    <= 2'b00;
      r_vreq   <= 1'b0;
    end else begin
      r_sel    <= w_sel_nxt;
      r_ptr    <= w_ptr_nxt;
      r_rd     <= w_rd_nxt;
      r_ack    <= w_ack_nxt;
      r_dout   <= w_dout_nxt;
      r_vaddr  <= w_vaddr_nxt;
      r_vwdata <= w_vwdata_nxt;
      r_vwe    <= w_vwe_nxt;
      r_vreq   <= w_vreq_nxt;
    end
  end

  // scroll/control register file, written through the select latch
  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= 16'h0000;
      end
    end else if (w_reg_we) begin
      r_regs[r_sel] <= DIN;
    end else begin
      r_regs[r_sel] <= r_regs[r_sel];
    end
  end

  assign ACK        = r_ack;
  assign DOUT       = r_dout;
  assign VRAM_ADDR  = r_vaddr;
  assign VRAM_WDATA = r_vwdata;
  assign VRAM_WE    = r_vwe;
  assign VRAM_REQ   = r_vreq;
  assign RAM_PTR    = r_ptr;
  assign REG_RDATA  = r_regs[REG_RADDR];

endmodule

// File: tb/tb_gp9001_host_if.sv
// tb_gp9001_host_if: table-driven directed bench for gp9001_host_if, plus
// hand-written sequences for abort-before-ACK and reset mid-access.
import gp9001_pkg::*;

module tb_gp9001_host_if;

  localparam int AW = 14;
  localparam int RW = 4;

  localparam logic [5:0] S_SEL  = 6'b100000;
  localparam logic [5:0] S_WREG = 6'b010000;
  localparam logic [5:0] S_PTR  = 6'b001000;
  localparam logic [5:0] S_WRAM = 6'b000100;
  localparam logic [5:0] S_RDH  = 6'b000010;
  localparam logic [5:0] S_RDL  = 6'b000001;

  logic          CLK96;
  logic          RESET96;
  logic          OP_SELECT_REG, OP_WRITE_REG, OP_SET_RAM_PTR;
  logic          OP_WRITE_RAM, OP_READ_RAM_H, OP_READ_RAM_L;
  logic [15:0]   DIN;
  logic [1:0]    BE_N;
  logic          ACK;
  logic [15:0]   DOUT;
  logic [AW-1:0] VRAM_ADDR;
  logic [15:0]   VRAM_WDATA;
  logic [1:0]    VRAM_WE;
  logic          VRAM_REQ;
  logic          VRAM_OK;
  logic [15:0]   VRAM_RDATA;
  logic [RW-1:0] REG_RADDR;
  logic [15:0]   REG_RDATA;
  logic [AW-1:0] RAM_PTR;

  int n_checks = 0;
  int n_fail   = 0;

  gp9001_host_if #(.AW(AW), .RW(RW)) dut (
    .CLK96          (CLK96),
    .RESET96        (RESET96),
    .OP_SELECT_REG  (OP_SELECT_REG),
    .OP_WRITE_REG   (OP_WRITE_REG),
    .OP_SET_RAM_PTR (OP_SET_RAM_PTR),
    .OP_WRITE_RAM   (OP_WRITE_RAM),
    .OP_READ_RAM_H  (OP_READ_RAM_H),
    .OP_READ_RAM_L  (OP_READ_RAM_L),
    .DIN            (DIN),
    .BE_N           (BE_N),
    .ACK            (ACK),
    .DOUT           (DOUT),
    .VRAM_ADDR      (VRAM_ADDR),
    .VRAM_WDATA     (VRAM_WDATA),
    .VRAM_WE        (VRAM_WE),
    .VRAM_REQ       (VRAM_REQ),
    .VRAM_OK        (VRAM_OK),
    .VRAM_RDATA     (VRAM_RDATA),
    .REG_RADDR      (REG_RADDR),
    .REG_RDATA      (REG_RDATA),
    .RAM_PTR        (RAM_PTR)
  );

  initial CLK96 = 1'b0;
  always #5 CLK96 = ~CLK96;

  typedef struct packed {
    logic [5:0]  strb;
    logic [15:0] din;
    logic [1:0]  be_n;
    logic [3:0]  ok_dly;
    logic [15:0] rdata;
    logic        exp_req;
    logic [13:0] exp_addr;
    logic [1:0]  exp_we;
    logic [15:0] exp_wdata;
    logic [15:0] exp_dout;
    logic [13:0] exp_ptr;
    logic [3:0]  reg_idx;
    logic [15:0] exp_reg;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t mk(
    input logic [5:0] s, input logic [15:0] din, input logic [1:0] be_n,
    input logic [3:0] dly, input logic [15:0] rdata, input logic req,
    input logic [13:0] addr, input logic [1:0] we, input logic [15:0] wdata,
    input logic [15:0] dout, input logic [13:0] ptr, input logic [3:0] ridx,
    input logic [15:0] rval);
    vec_t v;
    v.strb = s; v.din = din; v.be_n = be_n; v.ok_dly = dly; v.rdata = rdata;
    v.exp_req = req; v.exp_addr = addr; v.exp_we = we; v.exp_wdata = wdata;
    v.exp_dout = dout; v.exp_ptr = ptr; v.reg_idx = ridx; v.exp_reg = rval;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive_strb(input logic [5:0] s);
    {OP_SELECT_REG, OP_WRITE_REG, OP_SET_RAM_PTR,
     OP_WRITE_RAM, OP_READ_RAM_H, OP_READ_RAM_L} = s;
  endtask

  // One full four-phase handshake with checks along the way
  task automatic run_vec(input vec_t v, input string p);
    @(negedge CLK96);
    DIN  = v.din;
    BE_N = v.be_n;
    drive_strb(v.strb);
    @(negedge CLK96);
    if (v.exp_req) begin
      check({p, " req"},  {31'd0, VRAM_REQ}, 32'd1);
      check({p, " ack_wait"}, {31'd0, ACK}, 32'd0);
      check({p, " addr"}, {18'd0, VRAM_ADDR}, {18'd0, v.exp_addr});
      check({p, " we"},   {30'd0, VRAM_WE}, {30'd0, v.exp_we});
      if (v.strb[2]) check({p, " wdata"}, {16'd0, VRAM_WDATA}, {16'd0, v.exp_wdata});
      repeat (int'(v.ok_dly) - 1) @(negedge CLK96);
      check({p, " req_held"}, {31'd0, VRAM_REQ}, 32'd1);
      VRAM_RDATA = v.rdata;
      VRAM_OK    = 1'b1;
      @(negedge CLK96);
      VRAM_OK    = 1'b0;
      VRAM_RDATA = 16'hDEAD;
    end else begin
      check({p, " no_req"}, {31'd0, VRAM_REQ}, 32'd0);
    end
    check({p, " ack"},      {31'd0, ACK}, 32'd1);
    check({p, " req_off"},  {31'd0, VRAM_REQ}, 32'd0);
    check({p, " we_off"},   {30'd0, VRAM_WE}, 32'd0);
    check({p, " dout"},     {16'd0, DOUT}, {16'd0, v.exp_dout});
    check({p, " ptr"},      {18'd0, RAM_PTR}, {18'd0, v.exp_ptr});
    drive_strb(6'b000000);
    @(negedge CLK96);
    check({p, " ack_drop"}, {31'd0, ACK}, 32'd0);
    REG_RADDR = v.reg_idx;
    #1;
    check({p, " reg"},      {16'd0, REG_RDATA}, {16'd0, v.exp_reg});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int quiet_err;
    RESET96    = 1'b1;
    drive_strb(6'b000000);
    DIN        = 16'h0000;
    BE_N       = 2'b11;
    VRAM_OK    = 1'b0;
    VRAM_RDATA = 16'hDEAD;
    REG_RADDR  = 4'd0;

    // strobe, din, be_n, dly, rdata, req, addr, we, wdata, dout, ptr, ridx, rval
    vecs[0]  = mk(S_SEL,          16'h0003, 2'b11, 4'd1, 16'h0000, 1'b0, 14'h0000, 2'b00, 16'h0000, 16'h0000, 14'h0000, REG_L1_SCROLL_Y, 16'h0000);
    vecs[1]  = mk(S_WREG,         16'hBEEF, 2'b11, 4'd1, 16'h0000, 1'b0, 14'h0000, 2'b00, 16'h0000, 16'h0000, 14'h0000, REG_L1_SCROLL_Y, 16'hBEEF);
    vecs[2]  = mk(S_PTR,          16'h1000, 2'b11, 4'd1, 16'h0000, 1'b0, 14'h0000, 2'b00, 16'h0000, 16'h0000, 14'h1000, REG_L1_SCROLL_Y, 16'hBEEF);
    vecs[3]  = mk(S_WRAM,         16'h1234, 2'b00, 4'd3, 16'h0000, 1'b1, 14'h1000, 2'b11, 16'h1234, 16'h0000, 14'h1001, REG_L1_SCROLL_Y, 16'hBEEF);
    vecs[4]  = mk(S_PTR,          16'hFFFF, 2'b11, 4'd1, 16'h0000, 1'b0, 14'h0000, 2'b00, 16'h0000, 16'h0000, 14'h3FFF, REG_L1_SCROLL_Y, 16'hBEEF);
    vecs[5]  = mk(S_RDH,          16'h0000, 2'b11, 4'd2, 16'hA5A5, 1'b1, 14'h3FFF, 2'b00, 16'h0000, 16'hA5A5, 14'h0000, REG_L1_SCROLL_Y, 16'hBEEF);
    vecs[6]  = mk(S_RDL,          16'h0000, 2'b11, 4'd1, 16'h5A5A, 1'b1, 14'h0000, 2'b00, 16'h0000, 16'h5A5A, 14'h0001, REG_L1_SCROLL_Y, 16'hBEEF);
    vecs[7]  = mk(S_WRAM,         16'h00CC, 2'b10, 4'd1, 16'h0000, 1'b1, 14'h0001, 2'b01, 16'h00CC, 16'h5A5A, 14'h0002, REG_L1_SCROLL_Y, 16'hBEEF);
    vecs[8]  = mk(S_WRAM,         16'h5555, 2'b11, 4'd2, 16'h0000, 1'b1, 14'h0002, 2'b00, 16'h5555, 16'h5A5A, 14'h0003, REG_L1_SCROLL_Y, 16'hBEEF);
    vecs[9]  = mk(S_SEL | S_WRAM, 16'h0005, 2'b00, 4'd1, 16'h0000, 1'b0, 14'h0000, 2'b00, 16'h0000, 16'h5A5A, 14'h0003, REG_L2_SCROLL_Y, 16'h0000);
    vecs[10] = mk(S_WREG,         16'h7777, 2'b11, 4'd1, 16'h0000, 1'b0, 14'h0000, 2'b00, 16'h0000, 16'h5A5A, 14'h0003, REG_L2_SCROLL_Y, 16'h7777);
    vecs[11] = mk(S_SEL,          16'hFFF8, 2'b11, 4'd1, 16'h0000, 1'b0, 14'h0000, 2'b00, 16'h0000, 16'h5A5A, 14'h0003, REG_CTRL,        16'h0000);
    vecs[12] = mk(S_WREG,         16'h0101, 2'b11, 4'd1, 16'h0000, 1'b0, 14'h0000, 2'b00, 16'h0000, 16'h5A5A, 14'h0003, REG_CTRL,        16'h0101);

    repeat (3) @(negedge CLK96);
    #1;
    check("rst ack",   {31'd0, ACK}, 32'd0);
    check("rst dout",  {16'd0, DOUT}, 32'd0);
    check("rst req",   {31'd0, VRAM_REQ}, 32'd0);
    check("rst we",    {30'd0, VRAM_WE}, 32'd0);
    check("rst addr",  {18'd0, VRAM_ADDR}, 32'd0);
    check("rst wdata", {16'd0, VRAM_WDATA}, 32'd0);
    check("rst ptr",   {18'd0, RAM_PTR}, 32'd0);
    check("rst reg0",  {16'd0, REG_RDATA}, 32'd0);
    @(negedge CLK96);
    RESET96 = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // Abort: strobe dropped before VRAM_OK -> access completes, no ACK
    @(negedge CLK96);
    DIN = 16'h9999; BE_N = 2'b00;
    drive_strb(S_WRAM);
    @(negedge CLK96);
    check("abort req",  {31'd0, VRAM_REQ}, 32'd1);
    check("abort addr", {18'd0, VRAM_ADDR}, 32'h3);
    drive_strb(6'b000000);
    @(negedge CLK96);
    VRAM_OK = 1'b1;
    @(negedge CLK96);
    VRAM_OK = 1'b0;
    check("abort ack",     {31'd0, ACK}, 32'd0);
    check("abort req_off", {31'd0, VRAM_REQ}, 32'd0);
    check("abort ptr",     {18'd0, RAM_PTR}, 32'h4);
    @(negedge CLK96);
    check("abort ack2",    {31'd0, ACK}, 32'd0);

    // Reset asserted while a write is waiting for VRAM_OK
    DIN = 16'h4444; BE_N = 2'b00;
    drive_strb(S_WRAM);
    @(negedge CLK96);
    check("rstmid req_pre",  {31'd0, VRAM_REQ}, 32'd1);
    check("rstmid addr_pre", {18'd0, VRAM_ADDR}, 32'h4);
    RESET96 = 1'b1;
    #1;
    check("rstmid req",  {31'd0, VRAM_REQ}, 32'd0);
    check("rstmid ack",  {31'd0, ACK}, 32'd0);
    check("rstmid ptr",  {18'd0, RAM_PTR}, 32'd0);
    check("rstmid addr", {18'd0, VRAM_ADDR}, 32'd0);
    check("rstmid we",   {30'd0, VRAM_WE}, 32'd0);
    REG_RADDR = 4'd3;
    #1;
    check("rstmid reg3", {16'd0, REG_RDATA}, 32'd0);
    drive_strb(6'b000000);
    @(negedge CLK96);
    RESET96 = 1'b0;
    quiet_err = 0;
    repeat (4) begin
      @(negedge CLK96);
      if (ACK !== 1'b0 || VRAM_REQ !== 1'b0) quiet_err++;
    end
    check("post_rst quiet", quiet_err, 32'd0);

    // WRITE_REG with the select latch cleared by reset lands in register 0
    run_vec(mk(S_WREG, 16'h4242, 2'b11, 4'd1, 16'h0000, 1'b0, 14'h0000, 2'b00,
               16'h0000, 16'h0000, 14'h0000, REG_L0_SCROLL_X, 16'h4242), "wreg_sel0");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
